dbus_arbiter: RTL and testbench
===============================

Name: dbus_arbiter

Overview:
- Two-master, three-slave data-bus arbiter and sequencer for the CPU data path.
- Master 0 is the CPU load/store port. Master 1 is a second requester, such as a DMA or UART block-transfer engine.
- Shares one slave-side address/data/strobe bus between DataMem, Peripheral and UART.
- Decodes the address into a one-hot slave select, returns registered read data, and flags accesses to unmapped addresses.

Parameters:
- PERI_BASE, 32'h4000_0000: addresses below this select RAM.
- UART_BASE, 32'h4000_0018: [PERI_BASE, UART_BASE) selects Peripheral.
- UART_TOP, 32'h4000_0030: [UART_BASE, UART_TOP) selects UART; addresses >= UART_TOP are unmapped.
- FIXED_PRIO, 0: 0 = round-robin; 1 = master 0 always wins a simultaneous request.

Ports:
- sysclk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 request; held until m0_ack
- m0_wr  in  1  1 = write, 0 = read
- m0_addr  in  32  byte address; stable while m0_req
- m0_wdata  in  32  write data
- m0_rdata  out  32  read data; valid when m0_ack
- m0_ack  out  1  one-cycle completion pulse
- m0_err  out  1  qualifies m0_ack: unmapped address
- m1_req, m1_wr, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err: same as master 0, for master 1
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_rd  out  1  read strobe
- s_wr  out  1  write strobe
- s_sel  out  3  one-hot select: [0] RAM, [1] Peripheral, [2] UART
- ram_rdata, peri_rdata, uart_rdata  in  32 each  slave read data, combinational from s_addr
- gnt  out  2  one-hot current owner; 00 when idle
- m0_lock, m1_lock  in  1 each  only present with ARB_LOCK_EN

Behaviour:
- Reset: asynchronous, active-low. All outputs go to 0, the FSM goes to IDLE, and last_grant is set to 1 so master 0 wins first. Reset asserted mid-transfer drops strobes immediately; no ack is issued for the aborted transfer.
- FSM states:
  - IDLE: if any req is high, choose the winner, latch its addr/wdata/wr and the decoded select into registers, set gnt, go to ACCESS. Otherwise stay in IDLE.
  - ACCESS (exactly 1 cycle):
    - Drive s_addr/s_wdata from the latched values.
    - Strobe s_rd = ~wr or s_wr = wr, with s_sel = the decoded slave.
    - On read, capture the selected slave's rdata into the winner's rdata register at the end of the cycle.
    - Go to RESP.
  - RESP: pulse the winner's ack for 1 cycle, with err if unmapped. Clear gnt, update last_grant = winner, go to IDLE.
- Latency: req seen high in IDLE at cycle N -> strobe at N+1 -> ack at N+2. Back-to-back transfers for one master take 3 cycles each. The requester must deassert or re-present req in the cycle after ack.
- Arbitration:
  - Both requests high in IDLE, FIXED_PRIO=0: grant the master != last_grant.
  - Both requests high in IDLE, FIXED_PRIO=1: grant master 0.
  - Requests arriving during ACCESS or RESP are held and evaluated on the return to IDLE.
- Unmapped address (>= UART_TOP):
  - s_sel = 000 and no s_rd/s_wr strobe.
  - ack with err = 1 and rdata = 0.
  - Still takes 3 cycles.
- Address decode uses unsigned compares on the full 32 bits. Boundary values: PERI_BASE-1 -> RAM, PERI_BASE -> Peripheral, UART_BASE -> UART, UART_TOP -> unmapped.
- rdata registers: hold their value until the next read by the same master. A write ack leaves that master's rdata unchanged. The non-owning master's ack, err and rdata never change.
- Outside ACCESS: s_rd, s_wr and s_sel are 0; s_addr and s_wdata hold their last values.

Optional Feature:
- Macro: ARB_LOCK_EN.
- When defined:
  - m0_lock/m1_lock ports exist.
  - If the winner's lock is high at its RESP cycle and its req is high in the following IDLE cycle, that master is granted again regardless of the other master. This supports atomic read-modify-write.
  - The lock is released when the owner's lock is low at RESP.
  - A master holding lock while its req is low in IDLE loses the lock.
- When undefined: no lock ports; pure arbitration as above.

Test Plan:
- Master 0 read of 0x0000_0010 with ram_rdata = 32'hDEADBEEF -> s_rd and s_sel = 001 at N+1; m0_ack at N+2 with m0_rdata = DEADBEEF, m0_err = 0.
- Master 1 write of 32'h55 to 0x4000_000C -> s_wr, s_sel = 010, s_wdata = 55 at N+1; m1_ack at N+2; m0_ack stays 0.
- Both masters request reads continuously (FIXED_PRIO=0) -> grants alternate m0, m1, m0, m1, with an ack every 3 cycles; with FIXED_PRIO=1, only m0 is served.
- Master 0 read of 0x4000_0030 -> no strobe, s_sel = 000; m0_ack with m0_err = 1, m0_rdata = 0. Read of 0x4000_002C -> UART selected, err = 0.
- reset pulled low during ACCESS -> s_rd, s_wr and all acks drop in the same cycle. After release, master 0 wins a simultaneous request.
- With ARB_LOCK_EN: m1 locks for a read followed by a write while m0 also requests -> both m1 transfers complete before m0 is granted.

Source files
------------

// File: rtl/dbus_arbiter.sv
// Two-master, three-slave data-bus arbiter: each transfer runs IDLE -> ACCESS -> RESP.
// Define ARB_LOCK_EN to add m0_lock/m1_lock for locked back-to-back ownership.
module dbus_arbiter #(
    parameter logic [31:0] PERI_BASE  = 32'h4000_0000,
    parameter logic [31:0] UART_BASE  = 32'h4000_0018,
    parameter logic [31:0] UART_TOP   = 32'h4000_0030,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,
`ifdef ARB_LOCK_EN
    input  logic        m0_lock,
    input  logic        m1_lock,
`endif
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic        s_rd,
    output logic        s_wr,
    output logic [2:0]  s_sel,
    input  logic [31:0] ram_rdata,
    input  logic [31:0] peri_rdata,
    input  logic [31:0] uart_rdata,
    output logic [1:0]  gnt
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      r_state, w_next;
    logic        r_owner, r_last, r_wr;
    logic [31:0] r_addr, r_wdata, r_m0_rdata, r_m1_rdata;
    logic [2:0]  r_sel;
    logic [1:0]  w_req;
    logic        w_win;
    logic [31:0] w_sdata;
`ifdef ARB_LOCK_EN
    logic        r_locked, r_lock_m;
    logic [1:0]  w_lock;
    assign w_lock = {m1_lock, m0_lock};
`endif

    function automatic logic [2:0] decode(input logic [31:0] a);
        if (a < PERI_BASE)      return 3'b001;
        else if (a < UART_BASE) return 3'b010;
        else if (a < UART_TOP)  return 3'b100;
        else                    return 3'b000;
    endfunction

    assign w_req    = {m1_req, m0_req};
    assign s_addr   = r_addr;
    assign s_wdata  = r_wdata;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;

    // Winner: a single requester wins outright; a tie goes by priority mode.
    always_comb begin
        w_win = w_req[1] & ~w_req[0];
        if (w_req == 2'b11)
            w_win = FIXED_PRIO ? 1'b0 : ~r_last;
`ifdef ARB_LOCK_EN
        if (r_locked && w_req[r_lock_m])
            w_win = r_lock_m;
`endif
    end

    always_comb begin
        w_sdata = 32'h0;
        if (r_sel[0])      w_sdata = ram_rdata;
        else if (r_sel[1]) w_sdata = peri_rdata;
        else if (r_sel[2]) w_sdata = uart_rdata;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        s_rd   = 1'b0;
        s_wr   = 1'b0;
        s_sel  = 3'b000;
        gnt    = 2'b00;
        m0_ack = 1'b0;
        m1_ack = 1'b0;
        m0_err = 1'b0;
        m1_err = 1'b0;
        case (r_state)
            IDLE: if (|w_req) w_next = ACCESS;
            ACCESS: begin
                w_next = RESP;
                s_sel  = r_sel;
                s_rd   = ~r_wr & (|r_sel);
                s_wr   = r_wr & (|r_sel);
                gnt    = r_owner ? 2'b10 : 2'b01;
            end
            RESP: begin
                w_next = IDLE;
                gnt    = r_owner ? 2'b10 : 2'b01;
                m0_ack = ~r_owner;
                m1_ack = r_owner;
                m0_err = ~r_owner & (r_sel == 3'b000);
                m1_err = r_owner & (r_sel == 3'b000);
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_wr       <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_sel      <= 3'b000;
            r_m0_rdata <= 32'h0;
            r_m1_rdata <= 32'h0;
`ifdef ARB_LOCK_EN
            r_locked   <= 1'b0;
            r_lock_m   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_owner <= w_win;
                        r_wr    <= w_win ? m1_wr    : m0_wr;
                        r_addr  <= w_win ? m1_addr  : m0_addr;
                        r_wdata <= w_win ? m1_wdata : m0_wdata;
                        r_sel   <= decode(w_win ? m1_addr : m0_addr);
                    end
`ifdef ARB_LOCK_EN
                    if (r_locked && !w_req[r_lock_m])
                        r_locked <= 1'b0;
`endif
                end
                ACCESS: begin
                    // Unmapped reads capture zero since no slave is selected.
                    if (!r_wr) begin
                        if (r_owner) r_m1_rdata <= w_sdata;
                        else         r_m0_rdata <= w_sdata;
                    end
                end
                RESP: begin
                    r_last <= r_owner;
`ifdef ARB_LOCK_EN
                    r_locked <= w_lock[r_owner];
                    r_lock_m <= r_owner;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed vector table, corner sequences, and a
// transaction-level reference model driven by random requests.
module tb_dbus_arbiter;
    localparam bit          TB_FIXED_PRIO = 1'b0;
    localparam logic [31:0] PERI_BASE = 32'h4000_0000;
    localparam logic [31:0] UART_BASE = 32'h4000_0018;
    localparam logic [31:0] UART_TOP  = 32'h4000_0030;
    localparam int          NRAND     = 1500;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b0;
    logic        m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err, s_rd, s_wr;
    logic [2:0]  s_sel;
    logic [1:0]  gnt;
    logic [31:0] ram_rdata, peri_rdata, uart_rdata;
`ifdef ARB_LOCK_EN
    logic        m0_lock = 1'b0, m1_lock = 1'b0;
`endif

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_rd [2];

    always #5 sysclk = ~sysclk;

    // Slave models: each returns a distinct function of the address.
    assign ram_rdata  = s_addr ^ 32'hDEAD_BEFF;
    assign peri_rdata = s_addr ^ 32'h1234_5678;
    assign uart_rdata = ~s_addr;

    dbus_arbiter #(
        .PERI_BASE(PERI_BASE), .UART_BASE(UART_BASE), .UART_TOP(UART_TOP),
        .FIXED_PRIO(TB_FIXED_PRIO)
    ) dut (
        .sysclk(sysclk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
`ifdef ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rd(s_rd), .s_wr(s_wr), .s_sel(s_sel),
        .ram_rdata(ram_rdata), .peri_rdata(peri_rdata), .uart_rdata(uart_rdata),
        .gnt(gnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sysclk);
        #1;
    endtask

    task automatic put(input int m, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin m0_req = r; m0_wr = w; m0_addr = a; m0_wdata = d; end
        else        begin m1_req = r; m1_wr = w; m1_addr = a; m1_wdata = d; end
    endtask

    function automatic int region(input logic [31:0] a);
        if (a < PERI_BASE) return 0;
        if (a < UART_BASE) return 1;
        if (a < UART_TOP)  return 2;
        return 3;
    endfunction

    function automatic logic [31:0] slave_val(input logic [31:0] a);
        case (region(a))
            0:       return a ^ 32'hDEAD_BEFF;
            1:       return a ^ 32'h1234_5678;
            2:       return ~a;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] tbl [11];
        int k;
        tbl = '{32'h0, 32'h10, PERI_BASE - 1, PERI_BASE, PERI_BASE + 32'hC,
                UART_BASE - 1, UART_BASE, UART_TOP - 4, UART_TOP - 1, UART_TOP,
                32'hFFFF_FFFF};
        k = $urandom_range(0, 11);
        if (k == 11) return $urandom();
        return tbl[k];
    endfunction

    typedef struct {
        int          m;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  sel;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t tv [10];

    // Random-phase request and model state
    logic        rq [2], rq_wr [2];
    logic [31:0] rq_addr [2], rq_wd [2];

    initial begin
        int          strobe_at, ack_at, free_at, p_m, last_m;
        logic        p_wr;
        logic [31:0] p_addr, p_wd;
        logic [2:0]  e_sel;

        tv[0] = '{0, 1'b0, 32'h0000_0010, 32'h0,    3'b001, 1'b0, 32'hDEAD_BEEF};
        tv[1] = '{1, 1'b1, 32'h4000_000C, 32'h55,   3'b010, 1'b0, 32'h0};
        tv[2] = '{0, 1'b0, 32'h4000_0030, 32'h0,    3'b000, 1'b1, 32'h0};
        tv[3] = '{0, 1'b0, 32'h4000_002C, 32'h0,    3'b100, 1'b0, 32'hBFFF_FFD3};
        tv[4] = '{0, 1'b0, 32'h3FFF_FFFF, 32'h0,    3'b001, 1'b0, 32'hE152_4100};
        tv[5] = '{1, 1'b0, 32'h4000_0000, 32'h0,    3'b010, 1'b0, 32'h5234_5678};
        tv[6] = '{1, 1'b0, 32'h4000_0018, 32'h0,    3'b100, 1'b0, 32'hBFFF_FFE7};
        tv[7] = '{1, 1'b1, 32'h4000_0030, 32'hCAFE, 3'b000, 1'b1, 32'h0};
        tv[8] = '{0, 1'b1, 32'h4000_0017, 32'h1234, 3'b010, 1'b0, 32'h0};
        tv[9] = '{0, 1'b0, 32'hFFFF_FFFF, 32'h0,    3'b000, 1'b1, 32'h0};
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;

        // Reset state
        #1;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_sel", s_sel, 3'b000);
        chk("rst_strobe", {s_rd, s_wr}, 2'b00);
        chk("rst_ack", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        chk("rst_saddr", s_addr | s_wdata, 32'h0);
        repeat (2) @(posedge sysclk);
        @(negedge sysclk) reset = 1'b1;
        cyc();

        // Directed single transfers
        for (int i = 0; i < 10; i++) begin
            int o;
            o = 1 - tv[i].m;
            put(tv[i].m, 1'b1, tv[i].wr, tv[i].addr, tv[i].wdata);
            cyc();
            chk($sformatf("v%0d_gnt", i), gnt, tv[i].m ? 2'b10 : 2'b01);
            chk($sformatf("v%0d_sel", i), s_sel, tv[i].sel);
            chk($sformatf("v%0d_rd", i), s_rd, !tv[i].wr && tv[i].sel != 3'b000);
            chk($sformatf("v%0d_wr", i), s_wr, tv[i].wr && tv[i].sel != 3'b000);
            chk($sformatf("v%0d_addr", i), s_addr, tv[i].addr);
            if (tv[i].wr) chk($sformatf("v%0d_wdata", i), s_wdata, tv[i].wdata);
            chk($sformatf("v%0d_early_ack", i), {m0_ack, m1_ack}, 2'b00);
            cyc();
            if (!tv[i].wr) exp_rd[tv[i].m] = tv[i].rdata;
            chk($sformatf("v%0d_ack", i), tv[i].m ? m1_ack : m0_ack, 1'b1);
            chk($sformatf("v%0d_err", i), tv[i].m ? m1_err : m0_err, tv[i].err);
            chk($sformatf("v%0d_rdata", i), tv[i].m ? m1_rdata : m0_rdata, exp_rd[tv[i].m]);
            chk($sformatf("v%0d_other_ack", i), o ? {m1_ack, m1_err} : {m0_ack, m0_err}, 2'b00);
            chk($sformatf("v%0d_other_rdata", i), o ? m1_rdata : m0_rdata, exp_rd[o]);
            chk($sformatf("v%0d_resp_sel", i), {s_sel, s_rd, s_wr}, 5'b0);
            chk($sformatf("v%0d_hold_addr", i), s_addr, tv[i].addr);
            put(tv[i].m, 1'b0, 1'b0, 32'h0, 32'h0);
            cyc();
            chk($sformatf("v%0d_idle_gnt", i), gnt, 2'b00);
        end

        // Continuous contention; last owner was master 0
        put(0, 1'b1, 1'b0, 32'h20, 32'h0);
        put(1, 1'b1, 1'b0, 32'h4000_0004, 32'h0);
        for (int k = 1; k <= 17; k++) begin
            int j;
            logic a0, a1;
            cyc();
            j  = (k - 2) / 3;
            a0 = 1'b0;
            a1 = 1'b0;
            if (k >= 2 && (k - 2) % 3 == 0) begin
                if (TB_FIXED_PRIO || (j % 2 == 1)) a0 = 1'b1;
                else                               a1 = 1'b1;
            end
            chk($sformatf("alt_c%0d_ack0", k), m0_ack, a0);
            chk($sformatf("alt_c%0d_ack1", k), m1_ack, a1);
        end
        put(0, 1'b0, 1'b0, 32'h0, 32'h0);
        put(1, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc();

        // Reset in the middle of an access
        put(1, 1'b1, 1'b0, 32'h4000_0010, 32'h0);
        cyc();
        chk("mid_rst_pre_rd", s_rd, 1'b1);
        #1 reset = 1'b0;
        put(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("mid_rst_strobe", {s_rd, s_wr}, 2'b00);
        chk("mid_rst_sel", s_sel, 3'b000);
        chk("mid_rst_gnt", gnt, 2'b00);
        chk("mid_rst_ack", {m0_ack, m1_ack}, 2'b00);
        chk("mid_rst_rdata", m0_rdata | m1_rdata, 32'h0);
        @(negedge sysclk) reset = 1'b1;
        cyc();
        chk("post_rst_ack", {m0_ack, m1_ack}, 2'b00);
        put(0, 1'b1, 1'b0, 32'h8, 32'h0);
        put(1, 1'b1, 1'b0, 32'h4000_0010, 32'h0);
        cyc();
        chk("post_rst_gnt", gnt, 2'b01);
        cyc();
        chk("post_rst_ack0", m0_ack, 1'b1);
        chk("post_rst_ack1", m1_ack, 1'b0);
        chk("post_rst_rdata", m0_rdata, 32'hDEAD_BEF7);
        put(0, 1'b0, 1'b0, 32'h0, 32'h0);
        put(1, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        exp_rd[0] = 32'hDEAD_BEF7;
        exp_rd[1] = 32'h0;

`ifdef ARB_LOCK_EN
        // Locked read-modify-write by master 1 while master 0 waits
        put(1, 1'b1, 1'b0, 32'h10, 32'h0);
        m1_lock = 1'b1;
        cyc();
        chk("lk_gnt1", gnt, 2'b10);
        put(0, 1'b1, 1'b0, 32'h20, 32'h0);
        cyc();
        chk("lk_ack1", m1_ack, 1'b1);
        put(1, 1'b1, 1'b1, 32'h14, 32'h77);
        cyc();
        chk("lk_idle", gnt, 2'b00);
        cyc();
        chk("lk_gnt2", gnt, 2'b10);
        chk("lk_wr2", s_wr, 1'b1);
        m1_lock = 1'b0;
        cyc();
        chk("lk_ack2", m1_ack, 1'b1);
        chk("lk_ack2_m0", m0_ack, 1'b0);
        put(1, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        cyc();
        chk("lk_gnt3", gnt, 2'b01);
        cyc();
        chk("lk_ack3", m0_ack, 1'b1);
        put(0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        exp_rd[0] = 32'hDEAD_BEDF;
        exp_rd[1] = 32'hDEAD_BEEF;
`endif

        // Random traffic against the transaction-level model
        for (int m = 0; m < 2; m++) begin
            rq[m] = 1'b0; rq_wr[m] = 1'b0; rq_addr[m] = 32'h0; rq_wd[m] = 32'h0;
        end
        strobe_at = -1; ack_at = -1; free_at = 0; last_m = 0;
        p_m = 0; p_wr = 1'b0; p_addr = 32'h0; p_wd = 32'h0;
        for (int c = 0; c < NRAND; c++) begin
            if (c == ack_at) begin
                rq[p_m] = 1'b0;
                if (!p_wr) exp_rd[p_m] = slave_val(p_addr);
            end
            if (c > 0) begin
                e_sel = 3'b000;
                if (c == strobe_at && region(p_addr) < 3) e_sel = 3'b001 << region(p_addr);
                chk("r_gnt", gnt, (c == strobe_at || c == ack_at) ? (p_m ? 2'b10 : 2'b01) : 2'b00);
                chk("r_sel", s_sel, e_sel);
                chk("r_rd", s_rd, e_sel != 3'b000 && !p_wr);
                chk("r_wr", s_wr, e_sel != 3'b000 && p_wr);
                if (c == strobe_at) chk("r_addr", s_addr, p_addr);
                if (c == strobe_at && p_wr) chk("r_wdata", s_wdata, p_wd);
                chk("r_ack0", m0_ack, c == ack_at && p_m == 0);
                chk("r_ack1", m1_ack, c == ack_at && p_m == 1);
                chk("r_err0", m0_err, c == ack_at && p_m == 0 && region(p_addr) == 3);
                chk("r_err1", m1_err, c == ack_at && p_m == 1 && region(p_addr) == 3);
                chk("r_rdata0", m0_rdata, exp_rd[0]);
                chk("r_rdata1", m1_rdata, exp_rd[1]);
            end
            for (int m = 0; m < 2; m++) begin
                if (!rq[m] && $urandom_range(0, 2) != 0) begin
                    rq[m]      = 1'b1;
                    rq_wr[m]   = $urandom_range(0, 1) == 1;
                    rq_addr[m] = pick_addr();
                    rq_wd[m]   = $urandom();
                end
                put(m, rq[m], rq_wr[m], rq_addr[m], rq_wd[m]);
            end
            if (c >= free_at && (rq[0] || rq[1])) begin
                if (rq[0] && rq[1]) p_m = TB_FIXED_PRIO ? 0 : 1 - last_m;
                else                p_m = rq[1] ? 1 : 0;
                p_wr = rq_wr[p_m]; p_addr = rq_addr[p_m]; p_wd = rq_wd[p_m];
                strobe_at = c + 1; ack_at = c + 2; free_at = c + 3;
                last_m = p_m;
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
